// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map, FSM states and STATUS field layout for irq_ctrl
package irq_ctrl_pkg;
  localparam logic [1:0] IRQC_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] IRQC_ADDR_MODE   = 2'd1;
  localparam logic [1:0] IRQC_ADDR_ENABLE = 2'd2;
  localparam logic [1:0] IRQC_ADDR_STATUS = 2'd3;
  localparam int IRQC_ACTIVE_BIT = 31;
  localparam int IRQC_VEC_MSB    = 20;
  localparam int IRQC_VEC_LSB    = 16;
  localparam int IRQC_PEND_MSB   = 15;
  typedef enum logic [1:0] {
    IRQC_IDLE    = 2'd0,
    IRQC_ASSERT  = 2'd1,
    IRQC_SERVICE = 2'd2
  } irqc_state_e;
  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [4:0] irqc_lowest(input logic [15:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 15; i >= 0; i--) r = v[i] ? 5'(i) : r;
    return r;
  endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchroniser plus history flop giving level and rising-edge pulse
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  output logic level_o,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic hist_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], src_i};
      hist_q <= sync_q[STAGES-1];
    end
  end
  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~hist_q;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: bus-slave interrupt controller with edge/level capture, masking,
// fixed lowest-index priority and a claim/EOI handshake onto one cpu_irq line
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IRQ_CH-1:0] src_irq,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [1:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  output logic              cpu_irq
);
  logic gen_q;
  logic [IRQ_CH-1:0] mode_q, enable_q, pending_q, pending_d, level, rise, w1c;
  logic [4:0] vec_q, vec_d;
  irqc_state_e state_q, state_d;
  logic [31:0] rd_data_q, rd_val, status;
  logic rdy_q, acc, rd_en, wr_en, claim, eoi;
  logic [15:0] pend16, elig16, clr16;
  for (genvar i = 0; i < IRQ_CH; i++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .src_i  (src_irq[i]),
      .level_o(level[i]),
      .rise_o (rise[i])
    );
  end
  assign acc    = ~cs_ & ~as_;
  assign rd_en  = acc & rw;
  assign wr_en  = acc & ~rw;
  assign claim  = rd_en && addr == IRQC_ADDR_STATUS && state_q == IRQC_ASSERT;
  assign eoi    = wr_en && addr == IRQC_ADDR_STATUS && wr_data[31];
  assign pend16 = 16'(pending_q);
  assign elig16 = pend16 & 16'(enable_q);
  assign w1c    = (wr_en && addr == IRQC_ADDR_STATUS) ? wr_data[IRQ_CH-1:0] : '0;
  assign clr16  = claim ? 16'h1 << vec_q[3:0] : 16'h0;
  // Edge channels: new edge beats W1C and claim clear; level channels follow the input.
  assign pending_d = (mode_q & ((pending_q & ~w1c & ~IRQ_CH'(clr16)) | rise))
                   | (~mode_q & level);
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IRQC_IDLE: begin
        state_d = (gen_q && |elig16) ? IRQC_ASSERT : IRQC_IDLE;
        vec_d   = (gen_q && |elig16) ? irqc_lowest(elig16) : vec_q;
      end
      IRQC_ASSERT:  state_d = claim ? IRQC_SERVICE :
                              (!gen_q || !elig16[vec_q[3:0]]) ? IRQC_IDLE : IRQC_ASSERT;
      IRQC_SERVICE: state_d = eoi ? IRQC_IDLE : IRQC_SERVICE;
      default:      state_d = IRQC_IDLE;
    endcase
  end
  always_comb begin
    status = '0;
    status[IRQC_ACTIVE_BIT] = claim;
    status[IRQC_VEC_MSB:IRQC_VEC_LSB] = claim ? vec_q : 5'd0;
    status[IRQC_PEND_MSB:0] = pend16;
    rd_val = !rd_en                    ? 32'h0 :
             addr == IRQC_ADDR_CTRL    ? 32'(gen_q) :
             addr == IRQC_ADDR_MODE    ? 32'(mode_q) :
             addr == IRQC_ADDR_ENABLE  ? 32'(enable_q) : status;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_q     <= 1'b0;
      mode_q    <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      vec_q     <= '0;
      state_q   <= IRQC_IDLE;
      rd_data_q <= '0;
      rdy_q     <= 1'b1;
    end else begin
      gen_q     <= (wr_en && addr == IRQC_ADDR_CTRL) ? wr_data[0] : gen_q;
      mode_q    <= (wr_en && addr == IRQC_ADDR_MODE) ? wr_data[IRQ_CH-1:0] : mode_q;
      enable_q  <= (wr_en && addr == IRQC_ADDR_ENABLE) ? wr_data[IRQ_CH-1:0] : enable_q;
      pending_q <= pending_d;
      vec_q     <= vec_d;
      state_q   <= state_d;
      rd_data_q <= rd_val;
      rdy_q     <= ~acc;
    end
  end
  assign rd_data = rd_data_q;
  assign rdy_    = rdy_q;
  assign cpu_irq = state_q == IRQC_ASSERT;
endmodule
